fft_out_reorder32: RTL and testbench



---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_pingpong_ram.sv | 21 ++
 rtl/fft_out_reorder32.sv | 132 +++++++++++++
 tb/tb_fft_out_reorder32.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and helpers for the 32-point SDF FFT output stage.
package fft_pkg;
    localparam int N    = 32;
    localparam int LOGN = 5;
    localparam int DW   = 12;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    function automatic logic [LOGN-1:0] bitrev5(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int b = 0; b < LOGN; b++) r[b] = a[LOGN-1-b];
        return r;
    endfunction
endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank (2*N entries) simple dual-port sample RAM with a registered read port.
module fft_pingpong_ram
    import fft_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic            wr_bank,
    input  logic [LOGN-1:0] wr_addr,
    input  cplx_t           wr_data,
    input  logic            re,
    input  logic            rd_bank,
    input  logic [LOGN-1:0] rd_addr,
    output cplx_t           rd_data
);
    cplx_t mem [2*N];

    always_ff @(posedge clk) begin
        if (we) mem[{wr_bank, wr_addr}] <= wr_data;
        if (re) rd_data <= mem[{rd_bank, rd_addr}];
    end
endmodule

// File: rtl/fft_out_reorder32.sv
// Bit-reversed to natural-order reorder buffer for the 32-point SDF FFT output,
// ping-pong banked so consecutive frames stream without gaps.
module fft_out_reorder32
    import fft_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic signed [DW-1:0] data_in_r,
    input  logic signed [DW-1:0] data_in_i,
    output logic                 valid_o,
    output logic signed [DW-1:0] data_out_r,
    output logic signed [DW-1:0] data_out_i,
    output logic [LOGN-1:0]      index_o,
    output logic                 frame_o
);
    logic [LOGN-1:0] wr_cnt;
    logic            wr_bank;
    logic [1:0]      full, full_n;
    logic            we, wr_done, wr_blocked;

    rd_state_t       state, state_n;
    logic            rd_bank, rd_bank_n;
    logic [LOGN-1:0] rd_cnt, rd_cnt_n;
    logic            rd_en, rd_last, oldest;

    logic            vld_q, frm_q;
    logic [LOGN-1:0] idx_q;
    cplx_t           wr_data, rd_data;

    assign rd_last = (state == RD_READ) && (rd_cnt == LOGN'(N-1));

    // A full bank may only be refilled once its last read address is issuing;
    // a sample aimed at a still-occupied bank is dropped and the count holds.
    assign wr_blocked = full[wr_bank] && !(rd_last && (rd_bank == wr_bank));
    assign we         = valid_i && !wr_blocked;
    assign wr_done    = we && (wr_cnt == LOGN'(N-1));
    assign wr_data    = '{re: data_in_r, im: data_in_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (we) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LOGN'(N-1)) wr_bank <= ~wr_bank;
        end
    end

    always_comb begin
        full_n = full;
        if (rd_last) full_n[rd_bank] = 1'b0;
        if (wr_done) full_n[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) full <= '0;
        else     full <= full_n;
    end

    // With both banks full the older one is the bank the writer is waiting on.
    assign oldest = (&full) ? wr_bank : full[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RD_IDLE;
            rd_bank <= 1'b0;
            rd_cnt  <= '0;
        end else begin
            state   <= state_n;
            rd_bank <= rd_bank_n;
            rd_cnt  <= rd_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        rd_bank_n = rd_bank;
        rd_cnt_n  = rd_cnt;
        rd_en     = 1'b0;
        case (state)
            RD_IDLE: begin
                if (|full) begin
                    rd_bank_n = oldest;
                    rd_cnt_n  = '0;
                    state_n   = RD_READ;
                end
            end
            RD_READ: begin
                rd_en    = 1'b1;
                rd_cnt_n = rd_cnt + 1'b1;
                if (rd_last) begin
                    if (full[~rd_bank]) rd_bank_n = ~rd_bank;
                    else                state_n   = RD_IDLE;
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    fft_pingpong_ram u_ram (
        .clk     (clk),
        .we      (we),
        .wr_bank (wr_bank),
        .wr_addr (bitrev5(wr_cnt)),
        .wr_data (wr_data),
        .re      (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            frm_q <= 1'b0;
            idx_q <= '0;
        end else begin
            vld_q <= rd_en;
            frm_q <= rd_en && (rd_cnt == '0);
            if (rd_en) idx_q <= rd_cnt;
        end
    end

    // The RAM read register has no reset, so the data is qualified by the
    // resettable valid to keep the outputs at zero in and after reset.
    assign valid_o    = vld_q;
    assign frame_o    = frm_q;
    assign index_o    = idx_q;
    assign data_out_r = vld_q ? rd_data.re : '0;
    assign data_out_i = vld_q ? rd_data.im : '0;
endmodule

// File: tb/tb_fft_out_reorder32.sv
// Self-checking bench: a frame-level reference model (out[k] = in[bitrev(k)])
// scoreboards every output; table vectors plus hand-written reset/partial cases.
module tb_fft_out_reorder32;
    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     valid_i = 1'b0;
    logic signed [11:0]       data_in_r = '0;
    logic signed [11:0]       data_in_i = '0;
    logic                     valid_o;
    logic signed [11:0]       data_out_r;
    logic signed [11:0]       data_out_i;
    logic [4:0]               index_o;
    logic                     frame_o;

    always #5 clk = ~clk;

    fft_out_reorder32 dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .data_in_r  (data_in_r),
        .data_in_i  (data_in_i),
        .valid_o    (valid_o),
        .data_out_r (data_out_r),
        .data_out_i (data_out_i),
        .index_o    (index_o),
        .frame_o    (frame_o)
    );

    typedef struct {
        logic signed [11:0] r;
        logic signed [11:0] i;
        int                 k;
    } exp_t;

    typedef struct {
        int nframes;
        int gap;      // 0 contiguous, 1 alternate idle, 2 random idle
        int mode;     // 0 n/-n, 1 32f+n, 2 random
        int exp_lat;
        int exp_run;  // 0: not fixed
    } vec_t;

    exp_t               exp_q[$];
    logic signed [11:0] fr_q[$];
    logic signed [11:0] fi_q[$];
    int total = 0, bad = 0;
    int cyc = 0, cap_cyc = -1, first_vld = -1;
    int run = 0, max_run = 0, vld_seen = 0;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    function automatic int brev(int x);
        int r = 0;
        for (int b = 0; b < 5; b++)
            if (((x >> b) & 1) != 0) r += (1 << (4 - b));
        return r;
    endfunction

    task automatic check(string name, logic signed [31:0] act, logic signed [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_o) begin : mon
            exp_t e;
            vld_seen++;
            if (first_vld < 0) first_vld = cyc;
            run++;
            if (run > max_run) max_run = run;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got index %0d want no output (cycle %0d)", index_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("data_r", data_out_r, e.r);
                check("data_i", data_out_i, e.i);
                check("index", index_o, e.k);
                check("frame", frame_o, (e.k == 0));
            end
        end else begin
            run = 0;
        end
    end

    task automatic push_sample(logic signed [11:0] r, logic signed [11:0] i);
        fr_q.push_back(r);
        fi_q.push_back(i);
        if (fr_q.size() == 32) begin
            for (int k = 0; k < 32; k++) begin
                exp_t e;
                e.r = fr_q[brev(k)];
                e.i = fi_q[brev(k)];
                e.k = k;
                exp_q.push_back(e);
            end
            fr_q.delete();
            fi_q.delete();
            if (cap_cyc < 0) cap_cyc = cyc + 1;
        end
    endtask

    task automatic drive(logic signed [11:0] r, logic signed [11:0] i);
        @(negedge clk);
        valid_i   = 1'b1;
        data_in_r = r;
        data_in_i = i;
        push_sample(r, i);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            valid_i   = 1'b0;
            data_in_r = 12'($urandom());
            data_in_i = 12'($urandom());
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        fr_q.delete();
        fi_q.delete();
    endtask

    task automatic start_meas();
        cap_cyc   = -1;
        first_vld = -1;
        max_run   = 0;
        vld_seen  = 0;
    endtask

    task automatic drain(string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        idle(3);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic rand_frame(int nsamp);
        for (int n = 0; n < nsamp; n++) drive(12'($urandom()), 12'($urandom()));
    endtask

    initial begin
        vec_t vecs[4];
        logic signed [11:0] r, i;
        int t;

        vecs[0] = '{nframes: 1, gap: 0, mode: 0, exp_lat: 2, exp_run: 32};
        vecs[1] = '{nframes: 3, gap: 0, mode: 1, exp_lat: 2, exp_run: 96};
        vecs[2] = '{nframes: 1, gap: 1, mode: 0, exp_lat: 2, exp_run: 32};
        vecs[3] = '{nframes: 4, gap: 2, mode: 2, exp_lat: 2, exp_run: 0};

        // reset values
        repeat (3) @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_frame", frame_o, 0);
        check("rst_data_r", data_out_r, 0);
        check("rst_data_i", data_out_i, 0);
        check("rst_index", index_o, 0);
        rst = 1'b0;
        idle(2);

        for (int v = 0; v < 4; v++) begin
            start_meas();
            for (int f = 0; f < vecs[v].nframes; f++) begin
                for (int n = 0; n < 32; n++) begin
                    case (vecs[v].mode)
                        0:       begin r = 12'(n);          i = 12'(-n); end
                        1:       begin r = 12'(32 * f + n); i = 12'(-(32 * f + n)); end
                        default: begin r = 12'($urandom()); i = 12'($urandom()); end
                    endcase
                    drive(r, i);
                    if (vecs[v].gap == 1) idle(1);
                    else if (vecs[v].gap == 2) idle(int'($urandom_range(0, 2)));
                end
            end
            idle(1);
            drain($sformatf("vec%0d", v));
            check($sformatf("vec%0d_latency", v), first_vld - cap_cyc, vecs[v].exp_lat);
            if (vecs[v].exp_run > 0)
                check($sformatf("vec%0d_run", v), max_run, vecs[v].exp_run);
        end

        // partial frame held through a long idle, completed later
        start_meas();
        rand_frame(20);
        idle(100);
        check("partial_quiet", vld_seen, 0);
        rand_frame(12);
        idle(1);
        drain("partial");
        check("partial_latency", first_vld - cap_cyc, 2);
        check("partial_run", max_run, 32);

        // reset while output k=10 is on the bus
        rand_frame(32);
        idle(1);
        t = 0;
        while (!(valid_o && index_o == 5'd10) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("midread_reached_k10", index_o, 10);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midread_rst_valid", valid_o, 0);
        check("midread_rst_frame", frame_o, 0);
        check("midread_rst_data_r", data_out_r, 0);
        check("midread_rst_data_i", data_out_i, 0);
        repeat (3) begin
            @(negedge clk);
            check("midread_hold_valid", valid_o, 0);
            check("midread_hold_data", data_out_r, 0);
        end
        rst = 1'b0;
        idle(2);
        start_meas();
        rand_frame(32);
        idle(1);
        drain("after_midread");
        check("after_midread_latency", first_vld - cap_cyc, 2);
        check("after_midread_run", max_run, 32);

        // reset after 17 samples of a frame; partial data must not survive
        rand_frame(17);
        @(negedge clk);
        valid_i = 1'b0;
        rst     = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("midwrite_rst_valid", valid_o, 0);
        rst = 1'b0;
        idle(2);
        start_meas();
        for (int n = 0; n < 32; n++) drive(12'(100 + n), 12'(-(100 + n)));
        idle(1);
        drain("midwrite");
        check("midwrite_latency", first_vld - cap_cyc, 2);
        check("midwrite_run", max_run, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
